// File: rtl/bcd_alu_seq.sv
// rtl/bcd_alu_seq.sv - digit-serial BCD add/subtract unit, one digit per clock, LSD first
// Optional signed-magnitude subtract result when BCD_ALU_SIGNED_EN is defined.
module bcd_alu_seq #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [4*NUM_DIGITS-1:0] left_i,
  input  logic [4*NUM_DIGITS-1:0] right_i,
  input  logic [1:0]              op_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [4*NUM_DIGITS-1:0] result_o,
  output logic                    carry_o,
  output logic                    neg_o,
  output logic                    err_o
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    l_sh, r_sh, res;
  logic [CW-1:0]   cnt;
  logic            c, carry, err, sub;
  logic            accept, bad, last;
  logic [3:0]      da, db, dig;
  logic            cin, is_sub, cout;
  logic [4:0]      sum5, dif5, adj;

  function automatic logic bad_digits(input logic [W-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  assign accept = in_valid_i && (state == IDLE);
  assign bad    = bad_digits(left_i) || bad_digits(right_i) || (op_i == 2'b11);
  assign last   = (cnt == CW'(NUM_DIGITS - 1));

  // Digit 0 is computed straight from the inputs at acceptance, so CALC only walks digits 1..N-1.
  always_comb begin
    da     = l_sh[3:0];
    db     = r_sh[3:0];
    cin    = c;
    is_sub = sub;
    if (state == IDLE) begin
      da     = left_i[3:0];
      db     = right_i[3:0];
      cin    = 1'b0;
      is_sub = op_i[1];
    end else if (state == FIX) begin
      da     = 4'd0;
      db     = res[3:0];
      is_sub = 1'b1;
    end
    sum5 = {1'b0, da} + {1'b0, db} + {4'd0, cin};
    dif5 = {1'b0, da} - {1'b0, db} - {4'd0, cin};
    if (is_sub) begin
      cout = dif5[4];
      adj  = cout ? dif5 + 5'd10 : dif5;
    end else begin
      cout = (sum5 > 5'd9);
      adj  = cout ? sum5 - 5'd10 : sum5;
    end
    dig = adj[3:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (accept) state_nxt = (bad || op_i == 2'b00) ? DONE : CALC;
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
`ifdef BCD_ALU_SIGNED_EN
          if (sub && cout) state_nxt = FIX;
`endif
        end
      end
      FIX: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BCD_ALU_SIGNED_EN
  logic neg;
  assign neg_o = neg;
`else
  assign neg_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      l_sh  <= '0;
      r_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      carry <= 1'b0;
      err   <= 1'b0;
      sub   <= 1'b0;
`ifdef BCD_ALU_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          carry <= 1'b0;
          err   <= 1'b0;
          c     <= 1'b0;
          cnt   <= CW'(1);
`ifdef BCD_ALU_SIGNED_EN
          neg   <= 1'b0;
`endif
          if (bad) begin
            res <= '0;
            err <= 1'b1;
          end else if (op_i == 2'b00) begin
            res <= left_i;
          end else begin
            l_sh <= left_i >> 4;
            r_sh <= right_i >> 4;
            sub  <= op_i[1];
            c    <= cout;
            res  <= {dig, res[W-1:4]};
          end
        end
        CALC: begin
          l_sh <= l_sh >> 4;
          r_sh <= r_sh >> 4;
          res  <= {dig, res[W-1:4]};
          c    <= cout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            carry <= cout;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef BCD_ALU_SIGNED_EN
            if (sub && cout) neg <= 1'b1;
`endif
          end
        end
        FIX: begin
          res <= {dig, res[W-1:4]};
          c   <= cout;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result_o = res;
  assign carry_o  = carry;
  assign err_o    = err;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb/tb_bcd_alu_seq.sv - directed-vector bench for bcd_alu_seq with NUM_DIGITS=4
module tb_bcd_alu_seq;

`ifdef BCD_ALU_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, carry, neg, err;
  logic [15:0] left, right, result;
  logic [1:0]  op;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bcd_alu_seq #(.NUM_DIGITS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .left_i(left), .right_i(right), .op_i(op), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .carry_o(carry), .neg_o(neg), .err_o(err)
  );

  // Presents one operation, returns outputs seen on the first out_valid cycle and the latency
  // counted in edges from the acceptance edge; completes the handshake if out_ready is high.
  task automatic do_op(input logic [15:0] l, input logic [15:0] r, input logic [1:0] o,
                       output int lat, output logic [15:0] res, output logic cy,
                       output logic ng, output logic er);
    int n;
    n = 0;
    left = l; right = r; op = o; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; left = 16'h9999; right = 16'h8888; op = 2'b10;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result; cy = carry; ng = neg; er = err;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic [20:0] got;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; left = '0; right = '0; op = 2'b00;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    got = {in_ready, out_valid, result, carry, neg, err};
    vectors++;
    if (got !== {2'b10, 16'h0000, 3'b000}) begin
      miscompares++;
      $display("FAIL reset {in_ready,out_valid,result,carry,neg,err} got %h exp %h", got, {2'b10, 16'h0000, 3'b000});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [15:0] l [3];
    logic [15:0] r [3];
    logic [26:0] exp_v [3];
    logic [26:0] got;
    logic [15:0] res;
    logic        cy, ng, er;
    int          lat;
    l     = '{16'h0958, 16'h9999, 16'h1234};
    r     = '{16'h0067, 16'h0001, 16'h4321};
    exp_v = '{{16'h1025, 3'b000, 8'd4}, {16'h0000, 3'b100, 8'd4}, {16'h5555, 3'b000, 8'd4}};
    for (int i = 0; i < 3; i++) begin
      do_op(l[i], r[i], 2'b01, lat, res, cy, ng, er);
      got = {res, cy, ng, er, 8'(lat)};
      vectors++;
      if (got !== exp_v[i]) begin
        miscompares++;
        $display("FAIL add[%0d] {result,carry,neg,err,latency} got %h exp %h", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] l [4];
    logic [15:0] r [4];
    logic [26:0] exp_v [4];
    logic [26:0] got;
    logic [15:0] res;
    logic        cy, ng, er;
    int          lat;
    l     = '{16'h0100, 16'h0001, 16'h5000, 16'h0000};
    r     = '{16'h0001, 16'h0002, 16'h5000, 16'h9999};
    exp_v = '{{16'h0099, 3'b000, 8'd4},
              SIGNED ? {16'h0001, 3'b110, 8'd8} : {16'h9999, 3'b100, 8'd4},
              {16'h0000, 3'b000, 8'd4},
              SIGNED ? {16'h9999, 3'b110, 8'd8} : {16'h0001, 3'b100, 8'd4}};
    for (int i = 0; i < 4; i++) begin
      do_op(l[i], r[i], 2'b10, lat, res, cy, ng, er);
      got = {res, cy, ng, er, 8'(lat)};
      vectors++;
      if (got !== exp_v[i]) begin
        miscompares++;
        $display("FAIL sub[%0d] {result,carry,neg,err,latency} got %h exp %h", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_err_none();
    logic [15:0] l [5];
    logic [15:0] r [5];
    logic [1:0]  o [5];
    logic [26:0] exp_v [5];
    logic [26:0] got;
    logic [15:0] res;
    logic        cy, ng, er;
    int          lat;
    l     = '{16'h00A0, 16'h1234, 16'h1234, 16'h4321, 16'h0A00};
    r     = '{16'h0001, 16'h1234, 16'h9F00, 16'h0000, 16'h0000};
    o     = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    exp_v = '{{16'h0000, 3'b001, 8'd1}, {16'h0000, 3'b001, 8'd1}, {16'h0000, 3'b001, 8'd1},
              {16'h4321, 3'b000, 8'd1}, {16'h0000, 3'b001, 8'd1}};
    for (int i = 0; i < 5; i++) begin
      do_op(l[i], r[i], o[i], lat, res, cy, ng, er);
      got = {res, cy, ng, er, 8'(lat)};
      vectors++;
      if (got !== exp_v[i]) begin
        miscompares++;
        $display("FAIL err_none[%0d] {result,carry,neg,err,latency} got %h exp %h", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res;
    logic        cy, ng, er;
    int          lat;
    logic [19:0] got;
    out_ready = 1'b0;
    do_op(16'h0958, 16'h0067, 2'b01, lat, res, cy, ng, er);
    left = 16'h1111; right = 16'h1111; op = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      got = {out_valid, in_ready, result, carry, err};
      vectors++;
      if (got !== {2'b10, 16'h1025, 2'b00}) begin
        miscompares++;
        $display("FAIL hold[%0d] {out_valid,in_ready,result,carry,err} got %h exp %h", i, got, {2'b10, 16'h1025, 2'b00});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL release {out_valid,in_ready} got %b exp 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] got;
    logic        seen;
    logic [15:0] res;
    logic        cy, ng, er;
    int          lat;
    left = 16'h1234; right = 16'h1111; op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    got = {in_ready, out_valid, result, carry, neg, err};
    vectors++;
    if (got !== {2'b10, 16'h0000, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_mid {in_ready,out_valid,result,carry,neg,err} got %h exp %h", got, {2'b10, 16'h0000, 3'b000});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_output out_valid_seen got %b exp 0", seen);
    end
    do_op(16'h0001, 16'h0001, 2'b01, lat, res, cy, ng, er);
    vectors++;
    if ({res, cy, er, 8'(lat)} !== {16'h0002, 2'b00, 8'd4}) begin
      miscompares++;
      $display("FAIL after_reset {result,carry,err,latency} got %h exp %h", {res, cy, er, 8'(lat)}, {16'h0002, 2'b00, 8'd4});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l [4];
    logic [15:0] r [4];
    logic [1:0]  o [4];
    logic [26:0] exp_v [4];
    logic [26:0] got;
    logic [15:0] res;
    logic        cy, ng, er;
    int          lat;
    l     = '{16'h0500, 16'h1000, 16'h9999, 16'h5000};
    r     = '{16'h0500, 16'h0001, 16'h0000, 16'h5000};
    o     = '{2'b01, 2'b10, 2'b00, 2'b01};
    exp_v = '{{16'h1000, 3'b000, 8'd4}, {16'h0999, 3'b000, 8'd4},
              {16'h9999, 3'b000, 8'd1}, {16'h0000, 3'b100, 8'd4}};
    for (int i = 0; i < 4; i++) begin
      do_op(l[i], r[i], o[i], lat, res, cy, ng, er);
      got = {res, cy, ng, er, 8'(lat)};
      vectors++;
      if (got !== exp_v[i]) begin
        miscompares++;
        $display("FAIL b2b[%0d] {result,carry,neg,err,latency} got %h exp %h", i, got, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_err_none();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
